// File: rtl/instr_mem_prog_if.sv
// Load/fetch bus of the programmable instruction memory.
// master = debug unit + fetch stage side, slave = memory side.
interface instr_mem_prog_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned BYTE_WIDTH = 8
);
    logic                  i_load_start;
    logic                  i_byte_valid;
    logic [BYTE_WIDTH-1:0] i_byte;
    logic                  i_valid;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_haltSignal;
    logic                  o_ready;
    logic [ADDR_WIDTH:0]   o_word_count;

    modport master (
        output i_load_start, i_byte_valid, i_byte, i_valid, i_address,
        input  o_data, o_haltSignal, o_ready, o_word_count
    );

    modport slave (
        input  i_load_start, i_byte_valid, i_byte, i_valid, i_address,
        output o_data, o_haltSignal, o_ready, o_word_count
    );
endinterface

// File: rtl/instr_mem_prog.sv
// Byte-stream-loadable instruction memory with registered, stall-aware fetch port.
// Optional INSTR_MEM_BOUNDS_EN: fetches at or beyond the loaded word count return HALT.
module instr_mem_prog #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned BYTE_WIDTH  = 8,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic              i_clk,
    input  logic              i_reset,
    instr_mem_prog_if.slave   bus
);

    localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [DATA_WIDTH-1:0] HALT_WORD = {HALT_OPCODE, {(DATA_WIDTH-6){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_shift_c;
    logic [CNT_W-1:0]      byte_cnt_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  halt_q;
    logic                  byte_take_c;
    logic                  word_wr_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    // Big-endian assembly: earlier bytes end up in the upper lanes.
    assign asm_shift_c = (asm_q << BYTE_WIDTH) | DATA_WIDTH'(bus.i_byte);

    // Next state and byte/word strobes; a load start always wins over a byte.
    always_comb begin
        state_d     = state_q;
        byte_take_c = 1'b0;
        word_wr_c   = 1'b0;
        if (bus.i_load_start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.i_byte_valid) begin
                        byte_take_c = 1'b1;
                        if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
                            word_wr_c = 1'b1;
                            if (asm_shift_c[DATA_WIDTH-1 -: 6] == HALT_OPCODE || wptr_q == '1) begin
                                state_d = READY;
                            end
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State register and load bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            asm_q        <= '0;
            byte_cnt_q   <= '0;
            wptr_q       <= '0;
            word_count_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == READY);
            if (bus.i_load_start) begin
                byte_cnt_q   <= '0;
                wptr_q       <= '0;
                word_count_q <= '0;
            end else if (byte_take_c) begin
                asm_q <= asm_shift_c;
                if (word_wr_c) begin
                    byte_cnt_q   <= '0;
                    wptr_q       <= wptr_q + 1'b1;
                    word_count_q <= word_count_q + 1'b1;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                end
            end
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (word_wr_c && !i_reset) begin
            mem[wptr_q] <= asm_shift_c;
        end
    end

`ifdef INSTR_MEM_BOUNDS_EN
    assign rd_word_c = ({1'b0, bus.i_address} >= word_count_q) ? HALT_WORD : mem[bus.i_address];
`else
    assign rd_word_c = mem[bus.i_address];
`endif

    // Fetch port: live only in READY, holds on stall, NOP otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
            halt_q <= 1'b0;
        end else if (state_q == READY) begin
            if (bus.i_valid) begin
                data_q <= rd_word_c;
                halt_q <= (rd_word_c[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
            end
        end else begin
            data_q <= '0;
            halt_q <= 1'b0;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_haltSignal = halt_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Randomized scoreboard bench for instr_mem_prog against a byte-queue reference model.
module tb_instr_mem_prog;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 7;
    localparam int unsigned BW    = 8;
    localparam int          DEPTH = 128;
    localparam logic [31:0] HALT  = 32'hFC000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();

    instr_mem_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        halt;
        logic        ready;
        logic [7:0]  wc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: 0 = idle, 1 = loading, 2 = ready
    int          m_st = 0;
    int          m_wc = 0;
    logic [7:0]  m_pend[$];
    logic [31:0] m_mem[DEPTH];
    logic [31:0] m_data = '0;
    logic        m_halt = 1'b0;

    function automatic logic [31:0] model_read(input int a);
`ifdef INSTR_MEM_BOUNDS_EN
        if (a >= m_wc) return HALT;
`endif
        return m_mem[a];
    endfunction

    function automatic void model_step(input logic r, input logic st, input logic bv,
                                       input logic [7:0] b, input logic v, input logic [6:0] a);
        logic [31:0] w;
        if (r) begin
            m_st = 0; m_wc = 0; m_pend.delete(); m_data = '0; m_halt = 1'b0;
            return;
        end
        if (m_st == 2) begin
            if (v) begin
                m_data = model_read(int'(a));
                m_halt = (m_data[31:26] == 6'h3F);
            end
        end else begin
            m_data = '0; m_halt = 1'b0;
        end
        if (st) begin
            m_st = 1; m_wc = 0; m_pend.delete();
        end else if (m_st == 1 && bv) begin
            m_pend.push_back(b);
            if (m_pend.size() == 4) begin
                w = '0;
                foreach (m_pend[i]) w = (w << 8) | 32'(m_pend[i]);
                m_mem[m_wc] = w;
                m_wc++;
                m_pend.delete();
                if (w[31:26] == 6'h3F || m_wc == DEPTH) m_st = 2;
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic st, input logic bv,
                         input logic [7:0] b, input logic v, input logic [6:0] a);
        exp_t e;
        rst              = r;
        bus.i_load_start = st;
        bus.i_byte_valid = bv;
        bus.i_byte       = b;
        bus.i_valid      = v;
        bus.i_address    = a;
        @(posedge clk);
        model_step(r, st, bv, b, v, a);
        e.data  = m_data;
        e.halt  = m_halt;
        e.ready = (m_st == 2);
        e.wc    = 8'(m_wc);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic tick();
        cycle(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom), 7'($urandom));
    endtask

    task automatic noise();
        cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 7'($urandom));
    endtask

    task automatic start_load();
        cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 1'($urandom), 7'($urandom));
    endtask

    task automatic put_byte(input logic [7:0] b);
        cycle(1'b0, 1'b0, 1'b1, b, 1'($urandom), 7'($urandom));
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps && ($urandom % 4 == 0)) tick();
            put_byte(8'(w >> (8 * (3 - i))));
        end
    endtask

    task automatic fetch(input logic [6:0] a, input logic v);
        cycle(1'b0, 1'b0, 1'b0, 8'($urandom), v, a);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_data",       bus.o_data,                  e.data);
                chk("o_haltSignal", 32'(bus.o_haltSignal),       32'(e.halt));
                chk("o_ready",      32'(bus.o_ready),            32'(e.ready));
                chk("o_word_count", 32'(bus.o_word_count),       32'(e.wc));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.i_load_start = 1'b0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = '0;
        bus.i_valid      = 1'b0;
        bus.i_address    = '0;

        repeat (3) cycle(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 7'($urandom));
        repeat (5) noise();

        // Fill the whole array without HALT: terminates on the last address
        start_load();
        for (int i = 0; i < DEPTH; i++) send_word(rand_word(), 1'b1);
        repeat (4) put_byte(8'($urandom));
        repeat (40) noise();

        // Three-word program ending in HALT
        start_load();
        send_word(32'h8C010001, 1'b0);
        send_word(32'h8C020002, 1'b0);
        send_word(HALT, 1'b0);
        fetch(7'd0, 1'b1);
        fetch(7'd2, 1'b1);
        fetch(7'd20, 1'b1);
        fetch(7'd1, 1'b1);
        repeat (3) fetch(7'($urandom), 1'b0);

        // Partial word discarded by a restart; the restart byte is dropped
        start_load();
        put_byte(8'hAA);
        put_byte(8'hBB);
        cycle(1'b0, 1'b1, 1'b1, 8'hCC, 1'b0, 7'd0);
        send_word(32'h00221020, 1'b0);
        send_word(HALT, 1'b0);
        fetch(7'd0, 1'b1);
        fetch(7'd1, 1'b1);
        fetch(7'd5, 1'b1);

        // Reset in the middle of a load
        start_load();
        repeat (6) put_byte(8'($urandom));
        cycle(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, 7'd0);
        fetch(7'd0, 1'b1);
        fetch(7'd1, 1'b1);
        start_load();
        repeat (3) send_word(rand_word(), 1'b1);
        send_word(HALT | 32'($urandom_range(0, 255)), 1'b0);
        repeat (20) fetch(7'($urandom_range(0, 7)), 1'($urandom));

        // Randomized programs, some left unterminated, with random restarts
        for (int k = 0; k < 12; k++) begin
            start_load();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n - 1; i++) send_word(rand_word(), 1'b1);
            if ($urandom % 4 != 0) send_word(HALT | (32'($urandom) & 32'h03FFFFFF), 1'b1);
            else repeat ($urandom_range(0, 3)) put_byte(8'($urandom));
            repeat (25) begin
                if ($urandom % 2 == 0) fetch(7'($urandom_range(0, 15)), 1'($urandom));
                else noise();
            end
        end

        repeat (2) tick();
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Programmable instruction memory for the MIPS pipeline. Replaces the fixed-content instruction memory: the debug unit streams the program in byte by byte over the UART path, and the block assembles the bytes into words and stores them until it sees a HALT word or the memory fills. The fetch stage then reads it with a registered, stall-aware read port that flags HALT instructions to the pipeline control.

## Interface
- `DATA_WIDTH`, 32: instruction word width; must be a multiple of `BYTE_WIDTH`.
- `ADDR_WIDTH`, 7: word address width; depth = 2^ADDR_WIDTH words.
- `BYTE_WIDTH`, 8: width of one load byte; BYTES = DATA_WIDTH/BYTE_WIDTH.
- `HALT_OPCODE`, 6'b111111: opcode field `word[DATA_WIDTH-1 -: 6]` that identifies HALT (HALT word = 32'hFC000000).

- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_load_start`  in  1  one-cycle pulse; starts a new program load.
- `i_byte_valid`  in  1  one-cycle qualifier for `i_byte`.
- `i_byte`  in  BYTE_WIDTH  load byte; first byte of each word is the MSB (big-endian).
- `i_valid`  in  1  fetch enable; low = stall, outputs hold.
- `i_address`  in  ADDR_WIDTH  fetch word address.
- `o_data`  out  DATA_WIDTH  fetched instruction, registered.
- `o_haltSignal`  out  1  high when `o_data` is a HALT word.
- `o_ready`  out  1  high when a program is loaded and fetch is live.
- `o_word_count`  out  ADDR_WIDTH+1  number of words written by the last load.

## Operation
- FSM states:
  - IDLE: after reset.
  - LOAD: accepting bytes.
  - READY: fetch live.
- Transitions:
  - `i_load_start` in any state -> LOAD; clears the word pointer, byte counter and `o_word_count`.
  - LOAD -> READY on the write of a HALT word.
  - LOAD -> READY on the write to the last address (2^ADDR_WIDTH-1).
- Byte assembly in LOAD:
  - Each `i_byte_valid` shifts `i_byte` into the assembly register and increments the byte counter.
  - On byte BYTES, the assembled word is written at the pointer on that same edge. The pointer and `o_word_count` increment, and the byte counter returns to 0.
- `i_byte_valid` in IDLE or READY is ignored.
- `i_load_start` and `i_byte_valid` in the same cycle: start wins and the byte is dropped.
- A partial word pending when `i_load_start` arrives is discarded.
- The HALT word itself is stored and counted.
- Fetch:
  - READY and `i_valid`: `o_data <= mem[i_address]`, `o_haltSignal <= (opcode == HALT_OPCODE)`.
  - READY and `!i_valid`: `o_data` and `o_haltSignal` hold.
  - Not READY: `o_data <= 0` (NOP) and `o_haltSignal <= 0`, regardless of `i_valid`.
- Reset values: `o_data`=0, `o_haltSignal`=0, `o_ready`=0, `o_word_count`=0, FSM=IDLE.
- Memory contents are not cleared by reset.
- Reset mid-load returns to IDLE; words already written stay in the array but are not fetchable until the next load completes.

## Timing
- Fetch latency is 1 cycle: the address is presented at edge N, and data plus halt flag are valid after edge N.
- A write at edge N is readable by a fetch issued at edge N+1 or later. A same-edge read of the address being written is impossible because fetch is gated off in LOAD.
- `o_ready` rises on the edge that writes the terminating word. The first valid fetch is issued on the next edge.
- `o_word_count` is updated on the same edge as each write.
- No backpressure on the byte stream: one byte per cycle is sustainable.

## Configuration
- `INSTR_MEM_BOUNDS_EN`:
  - Defined: in READY, a fetch with `i_address >= o_word_count` returns the HALT word (`{HALT_OPCODE, 0}`) and asserts `o_haltSignal`. This guarantees that running past the loaded program halts the pipeline.
  - Undefined: any address returns the stored array contents, including stale data from earlier loads.

## Test plan
- Reset, load 3 words (8C010001, 8C020002, FC000000) as 12 bytes -> `o_ready`=1 on the 12th byte edge, `o_word_count`=3; fetch addr 0 -> 8C010001 one cycle later, `o_haltSignal`=0.
- After that load, fetch addr 2 -> FC000000 with `o_haltSignal`=1. With `INSTR_MEM_BOUNDS_EN`, fetch addr 20 -> FC000000 with `o_haltSignal`=1; without it, fetch addr 20 returns the stored contents with `o_haltSignal` matching their opcode.
- Fetch addr 1, then drop `i_valid` for 3 cycles while changing `i_address` -> `o_data` holds 8C020002.
- Issue 2 bytes, then `i_load_start` together with a byte, then the 4 bytes of 00221020 and 4 bytes of FC000000 -> addr 0 reads 00221020, `o_word_count`=2.
- Load with ADDR_WIDTH=2 and no HALT: 4 words -> READY after word 4, `o_word_count`=4; a 5th word's bytes are ignored.
- Assert `i_reset` after 6 bytes of a load -> all outputs 0, IDLE; fetch returns 0; a new load proceeds normally.
